// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl: CBC chaining controller wrapped around a single-block AES core.
// Define AES_CBC_TIMEOUT_EN to enable the core_done watchdog and sticky err flag.
module aes_cbc_ctrl #(
  parameter int BLK_W          = 128,
  parameter int KEY_W          = 256,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic             cfg_enc_dec,
  input  logic [1:0]       cfg_mode,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             core_start,
  output logic             core_enc_dec,
  output logic [1:0]       core_mode,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_data_in,
  input  logic [BLK_W-1:0] core_data_out,
  input  logic             core_done,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               core_enc_dec_q, core_enc_dec_d;
  logic [1:0]         core_mode_q, core_mode_d;
  logic [KEY_W-1:0]   core_key_q, core_key_d;
  logic [BLK_W-1:0]   core_data_in_q, core_data_in_d;
  logic [BLK_W-1:0]   chain_q, chain_d;
  logic [BLK_W-1:0]   save_q, save_d;
  logic               last_q, last_d;
  logic [BLK_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

`ifdef AES_CBC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d        = state_q;
    core_enc_dec_d = core_enc_dec_q;
    core_mode_d    = core_mode_q;
    core_key_d     = core_key_q;
    core_data_in_d = core_data_in_q;
    chain_d        = chain_q;
    save_d         = save_q;
    last_d         = last_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    blk_cnt_d      = blk_cnt_q;
`ifdef AES_CBC_TIMEOUT_EN
    tmo_d          = tmo_q;
    err_d          = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          core_enc_dec_d = cfg_enc_dec;
          core_mode_d    = cfg_mode;
          core_key_d     = cfg_key;
          chain_d        = cfg_iv;
          blk_cnt_d      = '0;
`ifdef AES_CBC_TIMEOUT_EN
          err_d          = 1'b0;
`endif
          state_d        = LOAD;
        end
      end

      // Encipher folds the chain in before the core; decipher folds it in after.
      LOAD: begin
        if (in_valid) begin
          last_d         = in_last;
          save_d         = in_data;
          core_data_in_d = core_enc_dec_q ? in_data : (in_data ^ chain_q);
          state_d        = START;
        end
      end

      START: begin
`ifdef AES_CBC_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        if (core_done) begin
          if (core_enc_dec_q) begin
            out_data_d = core_data_out ^ chain_q;
            chain_d    = save_q;
          end else begin
            out_data_d = core_data_out;
            chain_d    = core_data_out;
          end
          out_last_d = last_q;
          blk_cnt_d  = blk_cnt_q + CNT_W'(1);
          state_d    = OUT;
        end
`ifdef AES_CBC_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      OUT: begin
        if (out_ready) begin
          state_d = last_q ? IDLE : LOAD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      core_enc_dec_q <= 1'b0;
      core_mode_q    <= 2'b00;
      core_key_q     <= '0;
      core_data_in_q <= '0;
      chain_q        <= '0;
      save_q         <= '0;
      last_q         <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      blk_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      core_enc_dec_q <= core_enc_dec_d;
      core_mode_q    <= core_mode_d;
      core_key_q     <= core_key_d;
      core_data_in_q <= core_data_in_d;
      chain_q        <= chain_d;
      save_q         <= save_d;
      last_q         <= last_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      blk_cnt_q      <= blk_cnt_d;
    end
  end

`ifdef AES_CBC_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Handshake and strobe outputs decode straight from the state register.
  assign in_ready     = (state_q == LOAD);
  assign core_start   = (state_q == START);
  assign out_valid    = (state_q == OUT);
  assign busy         = (state_q != IDLE);
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign core_enc_dec = core_enc_dec_q;
  assign core_mode    = core_mode_q;
  assign core_key     = core_key_q;
  assign core_data_in = core_data_in_q;
  assign blk_cnt      = blk_cnt_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// tb_aes_cbc_ctrl: known-answer vectors, randomized CBC messages and corner-case
// sequences for aes_cbc_ctrl, using a behavioural AES core stand-in.
module tb_aes_cbc_ctrl;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;
  localparam int CNT_W = 16;

  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [255:0] KEY0 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  typedef struct {
    logic         dec;
    logic [127:0] iv;
    logic [127:0] b0;
    logic [127:0] b1;
    logic [127:0] e0;
    logic [127:0] e1;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid, cfg_enc_dec;
  logic [1:0]       cfg_mode;
  logic [KEY_W-1:0] cfg_key;
  logic [BLK_W-1:0] cfg_iv;
  logic             in_valid, in_ready, in_last;
  logic [BLK_W-1:0] in_data;
  logic             out_valid, out_ready, out_last;
  logic [BLK_W-1:0] out_data;
  logic             core_start, core_enc_dec;
  logic [1:0]       core_mode;
  logic [KEY_W-1:0] core_key;
  logic [BLK_W-1:0] core_data_in;
  logic [BLK_W-1:0] core_data_out = '0;
  logic             core_done;
  logic             core_done_m = 1'b0;
  logic             stray_done = 1'b0;
  logic             busy, err;
  logic [CNT_W-1:0] blk_cnt;

  int checks = 0;
  int errors = 0;
  int core_lat = 2;
  bit done_en = 1'b1;
  bit lat_chk = 1'b1;
  logic [127:0] core_in_seen = '0;
  logic [127:0] msg_in [8];
  logic [127:0] msg_exp [8];
  vec_t vecs [2];

  assign core_done = core_done_m | stray_done;

  always #5 clk = ~clk;

  aes_cbc_ctrl #(
    .BLK_W(BLK_W), .KEY_W(KEY_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_enc_dec(cfg_enc_dec), .cfg_mode(cfg_mode),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_enc_dec(core_enc_dec), .core_mode(core_mode),
    .core_key(core_key), .core_data_in(core_data_in), .core_data_out(core_data_out),
    .core_done(core_done), .busy(busy), .blk_cnt(blk_cnt), .err(err)
  );

  // Stand-in block cipher: real AES answers for the known vectors, else an invertible toy.
  function automatic logic [127:0] toy_cipher(input logic dec, input logic [255:0] key,
                                              input logic [127:0] x);
    logic [127:0] t;
    if (!dec) begin
      if (x == (P1 ^ IV0)) return C1;
      if (x == (P2 ^ C1)) return C2;
      t = x ^ key[127:0];
      return {t[114:0], t[127:115]} ^ key[255:128];
    end else begin
      if (x == C1) return P1 ^ IV0;
      if (x == C2) return P2 ^ C1;
      t = x ^ key[255:128];
      return {t[12:0], t[127:13]} ^ key[127:0];
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural core: latches the block on core_start, answers after core_lat cycles.
  initial begin : core_model
    logic [127:0] x;
    logic         d;
    logic [255:0] k;
    forever begin
      @(negedge clk);
      if (core_start) begin
        x = core_data_in;
        d = core_enc_dec;
        k = core_key;
        core_in_seen = core_data_in;
        repeat (core_lat) @(negedge clk);
        core_data_out = toy_cipher(d, k, x);
        core_done_m = done_en;
        @(negedge clk);
        core_done_m = 1'b0;
        if (done_en && lat_chk) check_output("done_to_out_valid", {255'd0, out_valid}, 256'd1);
      end
    end
  end

  task automatic apply_stimulus(input logic dec, input logic [1:0] mode,
                                input logic [255:0] key, input logic [127:0] iv);
    cfg_valid = 1'b1; cfg_enc_dec = dec; cfg_mode = mode; cfg_key = key; cfg_iv = iv;
    @(negedge clk);
    cfg_valid = 1'b0;
    check_output("cfg_busy", {255'd0, busy}, 256'd1);
    check_output("cfg_in_ready", {255'd0, in_ready}, 256'd1);
    check_output("cfg_core_key", core_key, key);
    check_output("cfg_core_mode", {254'd0, core_mode}, {254'd0, mode});
    check_output("cfg_core_enc_dec", {255'd0, core_enc_dec}, {255'd0, dec});
    check_output("cfg_blk_cnt", {240'd0, blk_cnt}, 256'd0);
  endtask

  task automatic send_block(input logic [127:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check_output("in_ready_wait", {255'd0, in_ready}, 256'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("start_latency", {255'd0, core_start}, 256'd1);
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check_output({name, "_out_valid"}, {255'd0, out_valid}, 256'd1);
  endtask

  task automatic recv_block(input logic [127:0] exp, input logic last, input string name);
    wait_out_valid(name);
    check_output({name, "_data"}, {128'd0, out_data}, {128'd0, exp});
    check_output({name, "_last"}, {255'd0, out_last}, {255'd0, last});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_message(input logic dec, input logic [1:0] mode, input logic [255:0] key,
                             input logic [127:0] iv, input int len);
    logic [127:0] prev;
    apply_stimulus(dec, mode, key, iv);
    prev = iv;
    for (int i = 0; i < len; i++) begin
      send_block(msg_in[i], i == len - 1);
      recv_block(msg_exp[i], i == len - 1, "msg");
      check_output("core_data_in", {128'd0, core_in_seen},
                   {128'd0, dec ? msg_in[i] : (msg_in[i] ^ prev)});
      prev = dec ? msg_in[i] : msg_exp[i];
    end
    check_output("msg_end_busy", {255'd0, busy}, 256'd0);
    check_output("msg_end_blk_cnt", {240'd0, blk_cnt}, 256'(len));
  endtask

  initial begin : global_watchdog
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] global timeout");
  end

  initial begin : main
    logic         dec;
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] iv, prev;
    int           len;
    bit           seen;

    reset = 1'b0; cfg_valid = 1'b0; cfg_enc_dec = 1'b0; cfg_mode = 2'b00;
    cfg_key = '0; cfg_iv = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0;
    #12;
    check_output("rst_busy", {255'd0, busy}, 256'd0);
    check_output("rst_in_ready", {255'd0, in_ready}, 256'd0);
    check_output("rst_out_valid", {255'd0, out_valid}, 256'd0);
    check_output("rst_core_start", {255'd0, core_start}, 256'd0);
    check_output("rst_err", {255'd0, err}, 256'd0);
    check_output("rst_blk_cnt", {240'd0, blk_cnt}, 256'd0);
    check_output("rst_out_data", {128'd0, out_data}, 256'd0);
    check_output("rst_core_key", core_key, 256'd0);
    check_output("rst_core_data_in", {128'd0, core_data_in}, 256'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Known-answer vectors
    vecs[0] = '{1'b0, IV0, P1, P2, C1, C2};
    vecs[1] = '{1'b1, IV0, C1, C2, P1, P2};
    for (int v = 0; v < 2; v++) begin
      msg_in[0] = vecs[v].b0; msg_in[1] = vecs[v].b1;
      msg_exp[0] = vecs[v].e0; msg_exp[1] = vecs[v].e1;
      run_message(vecs[v].dec, 2'b00, KEY0, vecs[v].iv, 2);
    end

    // Randomized messages against the CBC reference model
    for (int m = 0; m < 8; m++) begin
      dec = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 2));
      key = {rand128(), rand128()};
      iv = rand128();
      len = $urandom_range(1, 4);
      core_lat = $urandom_range(1, 5);
      prev = iv;
      for (int i = 0; i < len; i++) begin
        msg_in[i] = rand128();
        if (!dec) begin
          msg_exp[i] = toy_cipher(1'b0, key, msg_in[i] ^ prev);
          prev = msg_exp[i];
        end else begin
          msg_exp[i] = toy_cipher(1'b1, key, msg_in[i]) ^ prev;
          prev = msg_in[i];
        end
      end
      run_message(dec, mode, key, iv, len);
    end

    // Stray cfg_valid while the core is busy, then output backpressure
    core_lat = 3;
    apply_stimulus(1'b0, 2'b00, KEY0, IV0);
    send_block(P1, 1'b0);
    cfg_valid = 1'b1; cfg_key = ~KEY0; cfg_mode = 2'b10; cfg_enc_dec = 1'b1; cfg_iv = '1;
    repeat (2) @(negedge clk);
    cfg_valid = 1'b0;
    check_output("stray_cfg_key", core_key, KEY0);
    check_output("stray_cfg_mode", {254'd0, core_mode}, 256'd0);
    check_output("stray_cfg_enc_dec", {255'd0, core_enc_dec}, 256'd0);
    wait_out_valid("bp");
    in_valid = 1'b1; in_data = P2; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output("bp_out_valid", {255'd0, out_valid}, 256'd1);
      check_output("bp_out_data", {128'd0, out_data}, {128'd0, C1});
      check_output("bp_in_ready", {255'd0, in_ready}, 256'd0);
      check_output("bp_core_start", {255'd0, core_start}, 256'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("bp_release_in_ready", {255'd0, in_ready}, 256'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("bp_release_start", {255'd0, core_start}, 256'd1);
    recv_block(C2, 1'b1, "bp2");
    check_output("bp_blk_cnt", {240'd0, blk_cnt}, 256'd2);
    check_output("bp_busy", {255'd0, busy}, 256'd0);

    // core_done pulse while waiting in LOAD is ignored
    apply_stimulus(1'b0, 2'b00, KEY0, IV0);
    send_block(P1, 1'b0);
    recv_block(C1, 1'b0, "ld1");
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check_output("ld_stray_out_valid", {255'd0, out_valid}, 256'd0);
    check_output("ld_stray_blk_cnt", {240'd0, blk_cnt}, 256'd1);
    check_output("ld_stray_in_ready", {255'd0, in_ready}, 256'd1);
    send_block(P2, 1'b1);
    recv_block(C2, 1'b1, "ld2");

    // Asynchronous reset in WAIT
    core_lat = 10;
    lat_chk = 1'b0;
    apply_stimulus(1'b0, 2'b00, KEY0, IV0);
    send_block(P1, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("arst_busy", {255'd0, busy}, 256'd0);
    check_output("arst_out_valid", {255'd0, out_valid}, 256'd0);
    check_output("arst_core_start", {255'd0, core_start}, 256'd0);
    check_output("arst_core_key", core_key, 256'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_output("arst_late_done_out_valid", {255'd0, seen}, 256'd0);
    lat_chk = 1'b1;
    core_lat = 2;
    msg_in[0] = P1; msg_in[1] = P2; msg_exp[0] = C1; msg_exp[1] = C2;
    run_message(1'b0, 2'b00, KEY0, IV0, 2);

    // Core that never answers
    done_en = 1'b0;
    core_lat = 1;
    apply_stimulus(1'b0, 2'b00, KEY0, IV0);
    send_block(P1, 1'b1);
    seen = 1'b0;
`ifdef AES_CBC_TIMEOUT_EN
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_output("wdog_err_before", {255'd0, err}, 256'd0);
    check_output("wdog_busy_before", {255'd0, busy}, 256'd1);
    @(negedge clk);
    check_output("wdog_err", {255'd0, err}, 256'd1);
    check_output("wdog_busy_after", {255'd0, busy}, 256'd0);
    check_output("wdog_no_output", {255'd0, seen | out_valid}, 256'd0);
    repeat (3) @(negedge clk);
    check_output("wdog_err_sticky", {255'd0, err}, 256'd1);
    done_en = 1'b1;
    apply_stimulus(1'b0, 2'b00, KEY0, IV0);
    check_output("wdog_err_cleared", {255'd0, err}, 256'd0);
    send_block(P1, 1'b1);
    recv_block(C1, 1'b1, "wdog_recover");
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_output("nodone_busy", {255'd0, busy}, 256'd1);
    check_output("nodone_err", {255'd0, err}, 256'd0);
    check_output("nodone_no_output", {255'd0, seen}, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    done_en = 1'b1;
    @(negedge clk);
    check_output("nodone_reset_busy", {255'd0, busy}, 256'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
